// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 16:1 register-file read mux among four requesters.
// Latency: grant at E0 drives mux_sel, data captured at E1, ack pulses E1-E2; one read per 3 cycles.
// Backpressure: requesters hold req/addr until their ack; losers simply wait, no abort path.
//
// Ports:
//   clk, reset_n   - clock (rising edge) and asynchronous active-low reset
//   req[3:0]       - level request per requester, held until ack
//   addr           - packed per-requester register addresses, SEL_W bits each
//   mux_sel        - registered select to the external read mux
//   mux_data       - combinational read-mux output, sampled one cycle after mux_sel changes
//   ack[3:0]       - one-hot, single-cycle acknowledge; rdata valid with it
//   rdata          - registered read data, held between acks
//   owner          - current / most recent grant index
//   busy           - high while a read is in flight (READ or ACK)

module regfile_read_arbiter #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           req,
  input  logic [4*SEL_W-1:0]   addr,
  output logic [SEL_W-1:0]     mux_sel,
  input  logic [DATA_W-1:0]    mux_data,
  output logic [3:0]           ack,
  output logic [DATA_W-1:0]    rdata,
  output logic [1:0]           owner,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          last_grant, last_grant_nxt;
  logic [SEL_W-1:0]    mux_sel_nxt;
  logic [3:0]          ack_nxt;
  logic [DATA_W-1:0]   rdata_nxt;
  logic [1:0]          owner_nxt;
  logic                busy_nxt;

  logic [1:0]          winner;
  logic                win_vld;
  logic [1:0]          cand;
  logic [SEL_W-1:0]    win_addr;

  // Round-robin pick: scan starting one past the last grant so the previous
  // winner ends up with the lowest priority. last_grant resets to 3, which
  // makes requester 0 the first in line after reset.
  always_comb begin
    winner  = last_grant;
    win_vld = 1'b0;
    cand    = last_grant;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!win_vld && req[cand]) begin
        winner  = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Address of the candidate winner; only registered at the grant edge, so
  // later addr changes cannot disturb an in-flight read.
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < 4; i++) begin
      if (winner == 2'(i)) begin
        win_addr = addr[SEL_W*i +: SEL_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output logic. ack defaults to zero so it can only
  // ever be a single-cycle pulse out of READ.
  always_comb begin
    state_nxt      = state;
    mux_sel_nxt    = mux_sel;
    owner_nxt      = owner;
    busy_nxt       = busy;
    rdata_nxt      = rdata;
    ack_nxt        = 4'b0000;
    last_grant_nxt = last_grant;

    unique case (state)
      IDLE: begin
        if (win_vld) begin
          mux_sel_nxt = win_addr;
          owner_nxt   = winner;
          busy_nxt    = 1'b1;
          state_nxt   = READ;
        end
      end
      READ: begin
        // mux_data has had a full period to settle on the registered select.
        rdata_nxt = mux_data;
        ack_nxt   = 4'b0001 << owner;
        state_nxt = ACK;
      end
      ACK: begin
        busy_nxt       = 1'b0;
        last_grant_nxt = owner;
        state_nxt      = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs and arbitration history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mux_sel    <= '0;
      ack        <= 4'b0000;
      rdata      <= '0;
      owner      <= 2'd0;
      busy       <= 1'b0;
      last_grant <= 2'd3;
    end else begin
      mux_sel    <= mux_sel_nxt;
      ack        <= ack_nxt;
      rdata      <= rdata_nxt;
      owner      <= owner_nxt;
      busy       <= busy_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule
